// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state, color type and frame geometry for the WS2812 grid driver
package ws2812_pkg;
  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
  typedef logic [23:0] grb_t;
  localparam int PIXELS = 64;
  localparam int BITS_PER_PIXEL = 24;
  function automatic grb_t cell_color(input logic live, input grb_t on_color);
    return live ? on_color : '0;
  endfunction
endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: shapes one WS2812 bit period; go restarts it, bit_done marks its final cycle
module ws2812_bit_timer #(
  parameter int T0H = 4,
  parameter int T1H = 9,
  parameter int BIT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);
  localparam int CW = $clog2(BIT_CYCLES);
  logic [CW-1:0] cnt;
  logic active;
  logic bv;
  assign bit_done = active && cnt == CW'(BIT_CYCLES - 1);
  assign dout = active && cnt < (bv ? CW'(T1H) : CW'(T0H));
  // go loads a new bit so bits chain with no gap; otherwise count through the period and stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      active <= 1'b0;
      bv <= 1'b0;
    end else if (go) begin
      cnt <= '0;
      active <= 1'b1;
      bv <= bit_val;
    end else if (bit_done) begin
      cnt <= '0;
      active <= 1'b0;
    end else if (active)
      cnt <= cnt + CW'(1);
endmodule

// File: rtl/ws2812_grid_driver.sv
// ws2812_grid_driver: serialises an 8x8 life grid onto a WS2812 chain, one frame per start
module ws2812_grid_driver
  import ws2812_pkg::*;
#(
  parameter int   T0H = 4,
  parameter int   T1H = 9,
  parameter int   BIT_CYCLES = 15,
  parameter int   RESET_CYCLES = 960,
  parameter grb_t ON_COLOR = 24'h00_10_00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] grid_in,
  output logic        led_dout,
  output logic        busy,
  output logic        frame_done
);
  localparam int PW = $clog2(PIXELS);
  localparam int BW = $clog2(BITS_PER_PIXEL);
  localparam int LW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  if (!(T0H >= 1 && T0H < T1H && T1H < BIT_CYCLES && RESET_CYCLES >= 1)) begin : g_bad_params
    $error("ws2812_grid_driver: illegal timing parameters");
  end
  state_t state;
  logic [PIXELS-1:0] snap;
  logic [PW-1:0] pix, npix;
  logic [BW-1:0] bitn, nbit;
  logic [LW-1:0] lcnt;
  logic go, bit_val, bit_done, wrap, last_bit, latch_end;
  grb_t first_color, next_color;
  assign busy = state != IDLE;
  assign latch_end = lcnt == LW'(RESET_CYCLES - 1);
  // the first bit comes straight from grid_in so the line rises on the accepting edge
  always_comb begin
    wrap = bitn == BW'(BITS_PER_PIXEL - 1);
    last_bit = bit_done && wrap && pix == PW'(PIXELS - 1);
    npix = wrap ? pix + PW'(1) : pix;
    nbit = wrap ? '0 : bitn + BW'(1);
    first_color = cell_color(grid_in[0], ON_COLOR);
    next_color = cell_color(snap[npix], ON_COLOR);
    go = (state == IDLE && start) || (state == SEND && bit_done && !last_bit);
    bit_val = state == IDLE ? first_color[23] : next_color[BW'(BITS_PER_PIXEL - 1) - nbit];
  end
  // frame sequencing: capture, walk pixels/bits, hold the latch low time, then report done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      snap <= '0;
      pix <= '0;
      bitn <= '0;
      lcnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE && start) begin
        snap <= grid_in;
        pix <= '0;
        bitn <= '0;
        state <= SEND;
      end else if (state == SEND && bit_done) begin
        pix <= last_bit ? '0 : npix;
        bitn <= last_bit ? '0 : nbit;
        lcnt <= '0;
        state <= last_bit ? LATCH : SEND;
      end else if (state == LATCH) begin
        lcnt <= latch_end ? '0 : lcnt + LW'(1);
        frame_done <= latch_end;
        state <= latch_end ? IDLE : LATCH;
      end
    end
  ws2812_bit_timer #(.T0H(T0H), .T1H(T1H), .BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk(clk),
    .rst_n(rst_n),
    .go(go),
    .bit_val(bit_val),
    .dout(led_dout),
    .bit_done(bit_done)
  );
endmodule

// File: tb/tb_ws2812_grid_driver.sv
// tb_ws2812_grid_driver: directed frames decoded from led_dout and compared with hand-computed values
module tb_ws2812_grid_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] grid_in = '0;
  logic led_dout, busy, frame_done;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nbits, bad_high, bad_period, busy_cnt, done_cnt, n9, n4, hi_len, last_rise, k;
  logic prev = 1'b0;
  logic [23:0] pw [64];

  always #5 clk = ~clk;

  ws2812_grid_driver dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .grid_in(grid_in),
    .led_dout(led_dout),
    .busy(busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nbits = 0; bad_high = 0; bad_period = 0; busy_cnt = 0; done_cnt = 0;
    n9 = 0; n4 = 0; hi_len = 0; last_rise = 0;
    for (int i = 0; i < 64; i++) pw[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (frame_done) done_cnt++;
    if (led_dout && !prev) begin
      if (nbits > 0 && cyc - last_rise != 15) bad_period++;
      last_rise = cyc;
      hi_len = 0;
    end
    if (led_dout) hi_len++;
    if (!led_dout && prev) begin
      if (hi_len == 9) n9++;
      else if (hi_len == 4) n4++;
      else bad_high++;
      if (nbits < 1536) pw[nbits / 24] = {pw[nbits / 24][22:0], hi_len == 9};
      nbits++;
    end
    prev = led_dout;
  endtask

  task automatic check_frame(input string tag, input logic [63:0] g);
    chk({tag, "_bits"}, 64'(nbits), 64'd1536);
    chk({tag, "_bad_high"}, 64'(bad_high), 64'd0);
    chk({tag, "_bad_period"}, 64'(bad_period), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd24000);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_pix%0d", tag, i), 64'(pw[i]), g[i] ? 64'h001000 : 64'h0);
  endtask

  initial begin
    clr();
    repeat (3) tick();
    chk("rst_led", 64'(led_dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", 64'(busy), 64'd0);
    // frame A: single live pixel, stray starts at cycles 500 and 23999
    grid_in = 64'h1;
    clr();
    start = 1'b1;
    tick();
    chk("A_start_busy", 64'(busy), 64'd1);
    chk("A_start_led", 64'(led_dout), 64'd1);
    for (int i = 1; i <= 24005; i++) begin
      start = (i == 500 || i == 23999);
      tick();
      if (i == 24000) begin
        chk("A_done_pulse", 64'(frame_done), 64'd1);
        chk("A_done_busy", 64'(busy), 64'd0);
      end
    end
    start = 1'b0;
    check_frame("A", 64'h1);
    chk("A_ones", 64'(n9), 64'd1);
    // frame B: all live, grid cleared at cycle 100
    grid_in = '1;
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 24005; i++) begin
      if (i == 100) grid_in = '0;
      tick();
    end
    check_frame("B", 64'hFFFF_FFFF_FFFF_FFFF);
    chk("B_hi9", 64'(n9), 64'd64);
    chk("B_hi4", 64'(n4), 64'd1472);
    // frame C: aborted by reset at cycle 5000
    grid_in = 64'h0000_0000_0000_2000;
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5000) tick();
    chk("C_busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("C_rst_led", 64'(led_dout), 64'd0);
    chk("C_rst_busy", 64'(busy), 64'd0);
    chk("C_rst_done", 64'(frame_done), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    clr();
    repeat (30) tick();
    chk("C_no_done", 64'(done_cnt), 64'd0);
    chk("C_waits_start", 64'(busy_cnt), 64'd0);
    // frame D: fresh frame with start held high, then back-to-back restart
    grid_in = 64'h8000_0001_F00F_0A05;
    clr();
    start = 1'b1;
    tick();
    chk("D_start_led", 64'(led_dout), 64'd1);
    k = 0;
    while (!frame_done && k < 24100) begin
      tick();
      k++;
    end
    chk("D_done_seen", 64'(frame_done), 64'd1);
    chk("D_done_busy", 64'(busy), 64'd0);
    chk("D_last_bit_plus_latch", 64'(cyc - last_rise), 64'd975);
    check_frame("D", 64'h8000_0001_F00F_0A05);
    clr();
    tick();
    chk("D_restart_busy", 64'(busy), 64'd1);
    chk("D_restart_led", 64'(led_dout), 64'd1);
    start = 1'b0;
    repeat (20) tick();
    chk("D_restart_running", 64'(busy), 64'd1);
    rst_n = 1'b0;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ws2812_grid_driver.md
WS2812_GRID_DRIVER -- requirements
Module: ws2812_grid_driver

Interface
REQ-001 Parameter T0H, default 4, high-time in clk cycles for a 0 bit (333 ns at 12 MHz).
REQ-002 Parameter T1H, default 9, high-time in clk cycles for a 1 bit (750 ns at 12 MHz).
REQ-003 Parameter BIT_CYCLES, default 15, total clk cycles per bit (1.25 us at 12 MHz).
REQ-004 Parameter RESET_CYCLES, default 960, low-time latch period after the last bit (80 us at 12 MHz).
REQ-005 Parameter ON_COLOR, default 24'h00_10_00, GRB word sent for a live cell; dead cell sends 24'h000000.
REQ-006 clk  input  1  single system clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-009 grid_in  input  64  8x8 cell grid from the life engine, bit i = pixel i.
REQ-010 led_dout  output  1  serial WS2812 data line.
REQ-011 busy  output  1  high from accepted start until frame complete.
REQ-012 frame_done  output  1  single-cycle pulse when a frame, including latch period, completes.

Function
REQ-013 The block SHALL implement states IDLE, SEND, LATCH.
REQ-014 In IDLE with start=1 at an edge, the block SHALL capture grid_in into an internal snapshot, enter SEND, and assert busy=1 and led_dout=1 after that edge.
REQ-015 grid_in changes after capture SHALL NOT affect the frame in progress.
REQ-016 Pixels SHALL be sent in order 0..63; each pixel SHALL be 24 bits, MSB first, with value ON_COLOR if snapshot[i]=1, else 24'h000000.
REQ-017 Each bit SHALL occupy exactly BIT_CYCLES cycles: led_dout high for T1H (bit=1) or T0H (bit=0) cycles, then low for the remainder.
REQ-018 Consecutive bits and pixels SHALL follow back-to-back with no idle cycles.
REQ-019 After bit 23 of pixel 63 completes, the block SHALL enter LATCH with led_dout=0 for exactly RESET_CYCLES cycles.
REQ-020 At the end of LATCH, the block SHALL enter IDLE, deassert busy, and pulse frame_done for exactly one cycle on the same edge.
REQ-021 busy SHALL stay high for exactly 64*24*BIT_CYCLES + RESET_CYCLES cycles per frame (23 040 + 960 = 24 000 at defaults).
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 start held high continuously SHALL launch a new frame on the first edge in IDLE, i.e. the edge after the frame_done pulse.
REQ-024 Bit, pixel and latch counters SHALL be sized by $clog2 of their maxima and wrap only under FSM control.
REQ-025 Parameter legality: 1 <= T0H < T1H < BIT_CYCLES and RESET_CYCLES >= 1; an elaboration-time check SHALL reject anything else.

Reset
REQ-026 On rst_n=0, the block SHALL immediately enter IDLE with led_dout=0, busy=0, frame_done=0, all counters 0 and the snapshot 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh start.

Structure
REQ-028 A shared package ws2812_pkg SHALL hold the state enum, the GRB color typedef (24 bits), and the PIXELS=64 / BITS_PER_PIXEL=24 constants.
REQ-029 One sub-module, ws2812_bit_timer, SHALL generate a single bit waveform (inputs: bit value and go; outputs: dout and bit_done), with the top FSM sequencing bits and pixels.

Verification
REQ-030 grid_in=64'h1, one start pulse -> pixel 0 decodes to 24'h001000, pixels 1..63 decode to 0, busy high for 24 000 cycles, one frame_done pulse.
REQ-031 grid_in=all ones -> every bit-1 high pulse is 9 cycles, every bit-0 high pulse is 4 cycles, every bit period is 15 cycles, 1536 bits total.
REQ-032 Change grid_in to 64'h0 at cycle 100 of the frame -> decoded frame still equals the value captured at start.
REQ-033 start pulses at cycles 500 and 23 999 of a frame -> both ignored, exactly one frame_done.
REQ-034 rst_n low at cycle 5000 of the frame -> led_dout=0 and busy=0 immediately; no frame_done; a new start produces a complete, correct frame.
REQ-035 start held high -> consecutive frames start the cycle after each frame_done, with a latch gap of exactly 960 low cycles.
